// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the ALU job sequencer.
// Signed operation is selected by defining ALU_SEQ_SIGNED_EN in the files that use it.
package alu_seq_pkg;

    localparam int ROM_AW_DEF = 9;
    localparam int DW_DEF     = 8;
    localparam int RW_DEF     = 16;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CAP_B,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_job_sequencer_mul.sv
// Repeated-addition multiplier: accumulator plus down counter. It handles
// two's-complement operands when ALU_SEQ_SIGNED_EN is defined.
module seq_mul_iter #(
    parameter int DW = 8,
    parameter int RW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          last,
    output logic [RW-1:0] result,
    output logic [DW-1:0] cnt
);

    logic [RW-1:0] acc_reg;
    logic [DW-1:0] cnt_reg;
    logic          neg_reg;
    logic [RW-1:0] a_ext;
    logic [RW-1:0] sum_next;
    logic [DW-1:0] b_mag;
    logic          b_neg;

`ifdef ALU_SEQ_SIGNED_EN
    // A negative B runs |B| iterations; the sign is restored on the final step.
    assign a_ext = {{(RW-DW){a[DW-1]}}, a};
    assign b_neg = b[DW-1];
    assign b_mag = b_neg ? (~b + 1'b1) : b;
`else
    assign a_ext = {{(RW-DW){1'b0}}, a};
    assign b_neg = 1'b0;
    assign b_mag = b;
`endif

    assign sum_next = acc_reg + a_ext;
    assign last     = (cnt_reg == {{(DW-1){1'b0}}, 1'b1});
    assign result   = neg_reg ? (~sum_next + 1'b1) : sum_next;
    assign cnt      = cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            neg_reg <= 1'b0;
        end else if (start) begin
            acc_reg <= '0;
            cnt_reg <= b_mag;
            neg_reg <= b_neg;
        end else if (cnt_reg != '0) begin
            acc_reg <= sum_next;
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

endmodule

// File: rtl/alu_job_sequencer.sv
// Job sequencer: accepts a job, reads A/B from consecutive ROM words, runs the
// operation and holds the result until consumed. Optional: ALU_SEQ_SIGNED_EN.
module alu_job_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ROM_AW = ROM_AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RW     = RW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [1:0]        job_op,
    input  logic [ROM_AW-1:0] job_addr,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DW-1:0]     rom_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RW-1:0]     res_data,
    output logic [1:0]        res_op,
    output logic              busy,
    output logic [DW-1:0]     iter_cnt
);

    state_t            state_reg;
    logic [1:0]        op_reg;
    logic [DW-1:0]     a_reg;
    logic [DW-1:0]     b_reg;
    logic              job_ready_reg;
    logic              busy_reg;
    logic              rom_en_reg;
    logic [ROM_AW-1:0] rom_addr_reg;
    logic              res_valid_reg;
    logic [RW-1:0]     res_data_reg;
    logic [1:0]        res_op_reg;

    logic [DW-1:0]     sum8;
    logic [DW-1:0]     diff8;
    logic [RW-1:0]     sum_ext;
    logic [RW-1:0]     diff_ext;
    logic [RW-1:0]     pass_ext;
    logic              mul_start;
    logic              mul_last;
    logic [RW-1:0]     mul_result;
    logic [DW-1:0]     mul_cnt;

    assign sum8  = a_reg + b_reg;
    assign diff8 = a_reg - b_reg;

`ifdef ALU_SEQ_SIGNED_EN
    assign sum_ext  = {{(RW-DW){sum8[DW-1]}}, sum8};
    assign diff_ext = {{(RW-DW){diff8[DW-1]}}, diff8};
    assign pass_ext = {{(RW-DW){a_reg[DW-1]}}, a_reg};
`else
    assign sum_ext  = {{(RW-DW){1'b0}}, sum8};
    assign diff_ext = {{(RW-DW){1'b0}}, diff8};
    assign pass_ext = {{(RW-DW){1'b0}}, a_reg};
`endif

    // Zero operands short-circuit to a zero product without entering MUL.
    assign mul_start = (state_reg == S_EXEC) && (op_reg == OP_MUL) &&
                       (a_reg != '0) && (b_reg != '0);

    seq_mul_iter #(
        .DW (DW),
        .RW (RW)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (a_reg),
        .b      (b_reg),
        .last   (mul_last),
        .result (mul_result),
        .cnt    (mul_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            job_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            rom_en_reg    <= 1'b0;
            rom_addr_reg  <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_op_reg    <= '0;
        end else begin
            unique case (state_reg)
                S_IDLE: begin
                    if (job_valid && job_ready_reg) begin
                        op_reg        <= job_op;
                        rom_en_reg    <= 1'b1;
                        rom_addr_reg  <= job_addr;
                        job_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_RD_A;
                    end else begin
                        job_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                S_RD_A: begin
                    rom_addr_reg <= rom_addr_reg + 1'b1;
                    state_reg    <= S_RD_B;
                end
                S_RD_B: begin
                    a_reg      <= rom_data;
                    rom_en_reg <= 1'b0;
                    state_reg  <= S_CAP_B;
                end
                S_CAP_B: begin
                    b_reg     <= rom_data;
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    if (mul_start) begin
                        state_reg <= S_MUL;
                    end else begin
                        unique case (op_reg)
                            OP_ADD:  res_data_reg <= sum_ext;
                            OP_SUB:  res_data_reg <= diff_ext;
                            OP_PASS: res_data_reg <= pass_ext;
                            OP_MUL:  res_data_reg <= '0;
                        endcase
                        res_op_reg    <= op_reg;
                        res_valid_reg <= 1'b1;
                        state_reg     <= S_DONE;
                    end
                end
                S_MUL: begin
                    if (mul_last) begin
                        res_data_reg  <= mul_result;
                        res_op_reg    <= op_reg;
                        res_valid_reg <= 1'b1;
                        state_reg     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        job_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign job_ready = job_ready_reg;
    assign busy      = busy_reg;
    assign rom_en    = rom_en_reg;
    assign rom_addr  = rom_addr_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_op    = res_op_reg;
    assign iter_cnt  = mul_cnt;

endmodule
